// File: rtl/czas_pkg.sv
// czas_pkg: shared types and BCD helpers for the time-of-day counter.
//   bcd_t      - one BCD digit (0..9)
//   hours_t    - HH as {tens (0..2), units (0..9)}
//   minutes_t  - MM as {tens (0..5), units (0..9)}
//   hours_inc / minutes_inc / minutes_last - per-digit BCD arithmetic,
//   no binary intermediate values.
package czas_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [1:0] MAX_HR2       = 2'd2;
    localparam bcd_t       MAX_HR1_AT_20 = 4'd3;
    localparam bcd_t       MAX_MIN2      = 4'd5;
    localparam bcd_t       MAX_DIGIT     = 4'd9;

    typedef struct packed {
        logic [1:0] hr2;
        bcd_t       hr1;
    } hours_t;

    typedef struct packed {
        bcd_t min2;
        bcd_t min1;
    } minutes_t;

    // 23 -> 00, x9 -> (x+1)0, otherwise units + 1.
    function automatic hours_t hours_inc(input hours_t h);
        hours_t r;
        r = h;
        if ((h.hr2 == MAX_HR2) && (h.hr1 == MAX_HR1_AT_20)) begin
            r = '0;
        end else if (h.hr1 == MAX_DIGIT) begin
            r.hr1 = '0;
            r.hr2 = h.hr2 + 2'd1;
        end else begin
            r.hr1 = h.hr1 + 4'd1;
        end
        return r;
    endfunction

    function automatic logic minutes_last(input minutes_t m);
        return (m.min2 == MAX_MIN2) && (m.min1 == MAX_DIGIT);
    endfunction

    // 59 -> 00 (caller decides whether that carries into hours).
    function automatic minutes_t minutes_inc(input minutes_t m);
        minutes_t r;
        r = m;
        if (minutes_last(m)) begin
            r = '0;
        end else if (m.min1 == MAX_DIGIT) begin
            r.min1 = '0;
            r.min2 = m.min2 + 4'd1;
        end else begin
            r.min1 = m.min1 + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/licznik_czasu_przycisk.sv
// przycisk: conditions one raw set button into single-cycle press events.
//   clk_i        - system clock
//   rst_async_ni - raw active-low reset, clears the input synchronizer
//   rst_ni       - internally synchronized active-low reset, clears the
//                  debounce / edge / repeat state
//   button_i     - raw asynchronous button level, active-high
//   press_o      - one-cycle press event
// Path: 2-flop synchronizer -> debounce counter -> rising-edge detect.
// Optional macro BTN_REPEAT_EN: while the accepted level stays high, an extra
// event fires every REPEAT_CYCLES cycles after the initial one.
module przycisk
    import czas_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_CYCLES   = 25_000_000
) (
    input  logic clk_i,
    input  logic rst_async_ni,
    input  logic rst_ni,
    input  logic button_i,
    output logic press_o
);

    localparam int unsigned     DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      sync_q, sync_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            level_q, level_d;
    logic            level_prev_q, level_prev_d;
    logic            press_q, press_d;
    logic            rise;

    // The synchronizer sits on the raw reset so it is already sampling the
    // button while the internal reset release is still propagating.
    always_comb begin
        sync_d = {sync_q[0], button_i};
    end

    always_ff @(posedge clk_i or negedge rst_async_ni) begin
        if (!rst_async_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    // Counter counts consecutive cycles of disagreement; the accepted level
    // flips on the cycle the count would reach DEBOUNCE_CYCLES.
    always_comb begin
        level_d      = level_q;
        db_cnt_d     = '0;
        level_prev_d = level_q;
        if (sync_q[1] != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                level_d = ~level_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    assign rise = level_q & ~level_prev_q;

`ifdef BTN_REPEAT_EN
    localparam int unsigned      REP_W    = $clog2(REPEAT_CYCLES);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_fire;

    // Counting starts the cycle after the initial event, so the first repeat
    // lands exactly REPEAT_CYCLES after it.
    always_comb begin
        rep_cnt_d = '0;
        rep_fire  = 1'b0;
        if (level_q && level_prev_q) begin
            if (rep_cnt_q == REP_LAST) begin
                rep_fire = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rep_cnt_q <= '0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
        end
    end

    always_comb begin
        press_d = rise | rep_fire;
    end
`else
    always_comb begin
        press_d = rise;
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            db_cnt_q     <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            press_q      <= 1'b0;
        end else begin
            db_cnt_q     <= db_cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_prev_d;
            press_q      <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/licznik_czasu.sv
// licznik_czasu: time-of-day counter producing HH:MM as BCD digits.
//   clk_i        - system clock
//   rst_i        - asynchronous reset, active-low (release synchronized)
//   tick_i       - one-cycle enable, one per second
//   button_hr_i  - raw hour-set button
//   button_min_i - raw minute-set button
//   hr2_o/hr1_o/min2_o/min1_o - BCD digits of HH:MM
//   colon_o      - toggles on every accepted tick
//   min_wrap_o   - one-cycle pulse when ticking rolls minutes 59 -> 00
// Optional macro BTN_REPEAT_EN enables button auto-repeat in przycisk.
module licznik_czasu
    import czas_pkg::*;
#(
    parameter int unsigned TICKS_PER_MIN   = 60,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_CYCLES   = 25_000_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_i,
    input  logic       button_hr_i,
    input  logic       button_min_i,
    output logic [1:0] hr2_o,
    output logic [3:0] hr1_o,
    output logic [3:0] min2_o,
    output logic [3:0] min1_o,
    output logic       colon_o,
    output logic       min_wrap_o
);

    localparam int unsigned      SEC_W    = $clog2(TICKS_PER_MIN);
    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(TICKS_PER_MIN - 1);

    logic rst_meta_q, rst_meta_d;
    logic rst_sync_q, rst_sync_d;

    always_comb begin
        rst_meta_d = 1'b1;
        rst_sync_d = rst_meta_q;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= rst_meta_d;
            rst_sync_q <= rst_sync_d;
        end
    end

    logic hr_press, min_press;

    przycisk #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_btn_hr (
        .clk_i        (clk_i),
        .rst_async_ni (rst_i),
        .rst_ni       (rst_sync_q),
        .button_i     (button_hr_i),
        .press_o      (hr_press)
    );

    przycisk #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_btn_min (
        .clk_i        (clk_i),
        .rst_async_ni (rst_i),
        .rst_ni       (rst_sync_q),
        .button_i     (button_min_i),
        .press_o      (min_press)
    );

    hours_t           hours_q, hours_d;
    minutes_t         minutes_q, minutes_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic             colon_q, colon_d;
    logic             min_wrap_q, min_wrap_d;
    logic             hr_step;

    // A minute press wins over a tick in the same cycle; an hour press and a
    // tick-driven minute carry merge into a single hour increment.
    always_comb begin
        hours_d    = hours_q;
        minutes_d  = minutes_q;
        sec_d      = sec_q;
        colon_d    = colon_q;
        min_wrap_d = 1'b0;
        hr_step    = hr_press;
        if (min_press) begin
            minutes_d = minutes_inc(minutes_q);
            sec_d     = '0;
        end else if (tick_i) begin
            colon_d = ~colon_q;
            if (sec_q == SEC_LAST) begin
                sec_d     = '0;
                minutes_d = minutes_inc(minutes_q);
                if (minutes_last(minutes_q)) begin
                    min_wrap_d = 1'b1;
                    hr_step    = 1'b1;
                end
            end else begin
                sec_d = sec_q + 1'b1;
            end
        end
        if (hr_step) begin
            hours_d = hours_inc(hours_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            hours_q    <= '0;
            minutes_q  <= '0;
            sec_q      <= '0;
            colon_q    <= 1'b0;
            min_wrap_q <= 1'b0;
        end else begin
            hours_q    <= hours_d;
            minutes_q  <= minutes_d;
            sec_q      <= sec_d;
            colon_q    <= colon_d;
            min_wrap_q <= min_wrap_d;
        end
    end

    assign hr2_o      = hours_q.hr2;
    assign hr1_o      = hours_q.hr1;
    assign min2_o     = minutes_q.min2;
    assign min1_o     = minutes_q.min1;
    assign colon_o    = colon_q;
    assign min_wrap_o = min_wrap_q;

endmodule

// File: tb/tb_licznik_czasu.sv
// Scoreboard bench for licznik_czasu (TICKS_PER_MIN=3, DEBOUNCE_CYCLES=4,
// REPEAT_CYCLES=8). Stimulus pushes hand-computed expected states into a
// queue; a monitor on the falling edge pops and compares them.
module tb_licznik_czasu;

    localparam int unsigned TPM = 3;
    localparam int unsigned DB  = 4;
    localparam int unsigned RC  = 8;

    logic       clk = 1'b0;
    logic       rst_i = 1'b0;
    logic       tick_i = 1'b0;
    logic       bh = 1'b0;
    logic       bm = 1'b0;
    logic [1:0] hr2;
    logic [3:0] hr1, min2, min1;
    logic       colon, wrap;

    always #5 clk = ~clk;

    licznik_czasu #(
        .TICKS_PER_MIN   (TPM),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_CYCLES   (RC)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .tick_i       (tick_i),
        .button_hr_i  (bh),
        .button_min_i (bm),
        .hr2_o        (hr2),
        .hr1_o        (hr1),
        .min2_o       (min2),
        .min1_o       (min1),
        .colon_o      (colon),
        .min_wrap_o   (wrap)
    );

    typedef struct {
        string       name;
        logic [15:0] exp;
    } chk_t;

    chk_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic exp_colon = 1'b0;

    // Monitor: compare every queued expectation against the outputs.
    always @(negedge clk) begin
        chk_t        c;
        logic [15:0] act;
        while (exp_q.size() > 0) begin
            c   = exp_q.pop_front();
            act = {hr2, hr1, min2, min1, colon, wrap};
            n_checks++;
            if (act !== c.exp) begin
                n_fail++;
                $display("FAIL %s: got %0d%0d:%0d%0d colon=%b wrap=%b, expected %0d%0d:%0d%0d colon=%b wrap=%b",
                         c.name, act[15:14], act[13:10], act[9:6], act[5:2], act[1], act[0],
                         c.exp[15:14], c.exp[13:10], c.exp[9:6], c.exp[5:2], c.exp[1], c.exp[0]);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_st(input string nm, input logic [1:0] h2, input logic [3:0] h1,
                             input logic [3:0] m2, input logic [3:0] m1, input logic w);
        chk_t c;
        c.name = nm;
        c.exp  = {h2, h1, m2, m1, exp_colon, w};
        exp_q.push_back(c);
    endtask

    task automatic tick_exp(input string nm, input logic [1:0] h2, input logic [3:0] h1,
                            input logic [3:0] m2, input logic [3:0] m1, input logic w);
        tick_i = 1'b1;
        cyc(1);
        tick_i = 1'b0;
        exp_colon = ~exp_colon;
        expect_st(nm, h2, h1, m2, m1, w);
        cyc(1);
        if (w) expect_st({nm, "_end"}, h2, h1, m2, m1, 1'b0);
    endtask

    // Press one or both buttons long enough for one event; optional tick
    // driven in the cycle the event is applied (t_counts: tick toggles colon).
    task automatic press(input logic h, input logic m, input logic t, input logic t_counts,
                         input logic chk, input string nm, input logic [1:0] h2,
                         input logic [3:0] h1, input logic [3:0] m2, input logic [3:0] m1,
                         input logic w);
        bh = h;
        bm = m;
        cyc(DB + 3);
        tick_i = t;
        cyc(1);
        tick_i = 1'b0;
        if (t && t_counts) exp_colon = ~exp_colon;
        if (chk) expect_st(nm, h2, h1, m2, m1, w);
        bh = 1'b0;
        bm = 1'b0;
        cyc(1);
        if (chk) expect_st({nm, "_next"}, h2, h1, m2, m1, 1'b0);
        cyc(DB + 3);
    endtask

    task automatic press_n(input logic h, input int n);
        for (int i = 0; i < n; i++)
            press(h, ~h, 1'b0, 1'b0, 1'b0, "", 2'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    endtask

    initial begin
        #1ms;
        n_fail++;
        $display("FAIL timeout: simulation did not finish, required completion within 1ms");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        // Reset state and basic ticking
        cyc(3);
        expect_st("reset", 2'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        cyc(1);
        rst_i = 1'b1;
        cyc(4);
        expect_st("post_reset", 2'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        tick_exp("tick1", 2'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        tick_exp("tick2", 2'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        tick_exp("tick3", 2'd0, 4'd0, 4'd0, 4'd1, 1'b0);

        // Preload 23:59 and roll to 00:00
        press_n(1'b1, 23);
        press_n(1'b0, 58);
        expect_st("preload_2359", 2'd2, 4'd3, 4'd5, 4'd9, 1'b0);
        tick_exp("roll_a", 2'd2, 4'd3, 4'd5, 4'd9, 1'b0);
        tick_exp("roll_b", 2'd2, 4'd3, 4'd5, 4'd9, 1'b0);
        tick_exp("wrap_2359", 2'd0, 4'd0, 4'd0, 4'd0, 1'b1);

        // Minute press at 00:59 with a coincident (ignored) tick
        press_n(1'b0, 59);
        expect_st("preload_0059", 2'd0, 4'd0, 4'd5, 4'd9, 1'b0);
        tick_exp("sec_one", 2'd0, 4'd0, 4'd5, 4'd9, 1'b0);
        press(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "min_no_carry", 2'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        tick_exp("sec_clr_a", 2'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        tick_exp("sec_clr_b", 2'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        tick_exp("sec_clr_c", 2'd0, 4'd0, 4'd0, 4'd1, 1'b0);
        bm = 1'b1;
        cyc(3);
        bm = 1'b0;
        cyc(DB + 6);
        expect_st("glitch", 2'd0, 4'd0, 4'd0, 4'd1, 1'b0);

        // Hour wrap and hour press coinciding with minute rollover
        press_n(1'b1, 23);
        expect_st("preload_2301", 2'd2, 4'd3, 4'd0, 4'd1, 1'b0);
        press(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "hr_wrap", 2'd0, 4'd0, 4'd0, 4'd1, 1'b0);
        press_n(1'b1, 5);
        press_n(1'b0, 58);
        expect_st("preload_0559", 2'd0, 4'd5, 4'd5, 4'd9, 1'b0);
        tick_exp("pre_a", 2'd0, 4'd5, 4'd5, 4'd9, 1'b0);
        tick_exp("pre_b", 2'd0, 4'd5, 4'd5, 4'd9, 1'b0);
        press(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, "hr_at_rollover", 2'd0, 4'd6, 4'd0, 4'd0, 1'b1);

        // Reset mid-debounce with the button held through release
        bm = 1'b1;
        cyc(2);
        rst_i = 1'b0;
        exp_colon = 1'b0;
        #1;
        expect_st("rst_async", 2'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        cyc(3);
        rst_i = 1'b1;
        cyc(DB + 3);
        expect_st("rst_db_early", 2'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        cyc(1);
        expect_st("rst_db_event", 2'd0, 4'd0, 4'd0, 4'd1, 1'b0);
        bm = 1'b0;
        cyc(DB + 4);

        // Long hold: auto-repeat adds three extra steps when enabled
        bm = 1'b1;
        cyc(30);
        bm = 1'b0;
        cyc(DB + 10);
`ifdef BTN_REPEAT_EN
        expect_st("long_hold", 2'd0, 4'd0, 4'd0, 4'd5, 1'b0);
`else
        expect_st("long_hold", 2'd0, 4'd0, 4'd0, 4'd2, 1'b0);
`endif
        cyc(2);
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
